legv8_multicycle_ctrl: RTL and testbench

- Multi-cycle control sequencer for the LEGv8 datapath: pc, instMem, decoder, registers, alu, data memory.
- Replaces the single-cycle combinational controller with an FSM, so instruction and data memory can be slow and share one memory port through a ready handshake.
- Sits between the decoder's opcode output and the datapath's mux selects and write strobes.

---
 rtl/legv8_multicycle_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_legv8_multicycle_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle control sequencer for the LEGv8 datapath with a shared, ready-handshaked memory port.
// Optional build macro CTRL_PERF_CNT_EN adds cycle and retired-instruction counters.
module legv8_multicycle_ctrl #(
    parameter int OPW  = 11,
    parameter int ALUW = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            run,
    input  logic [OPW-1:0]  opcode,
    input  logic            alu_zero,
    input  logic            mem_ready,
    output logic            inst_req,
    output logic            ir_write,
    output logic            pc_write,
    output logic [1:0]      pc_src,
    output logic            reg2Loc,
    output logic            aluSrc,
    output logic [ALUW-1:0] aluOp,
    output logic            memRead,
    output logic            memWrite,
    output logic            memToReg,
    output logic            regWrite,
    output logic [2:0]      state,
    output logic            illegal
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0]     cyc_cnt,
    output logic [31:0]     ret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC   = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100,
        S_HALT   = 3'b111
    } state_e;

    typedef enum logic [3:0] {
        C_ADD, C_SUB, C_AND, C_ORR, C_LD, C_ST, C_CBZ, C_B, C_ILL
    } cls_e;

    localparam logic [ALUW-1:0] ALU_AND   = ALUW'(4'b0000);
    localparam logic [ALUW-1:0] ALU_ORR   = ALUW'(4'b0001);
    localparam logic [ALUW-1:0] ALU_ADD   = ALUW'(4'b0010);
    localparam logic [ALUW-1:0] ALU_SUB   = ALUW'(4'b0110);
    localparam logic [ALUW-1:0] ALU_PASSB = ALUW'(4'b0111);

    state_e      state_q, state_d;
    cls_e        cls_q, cls_d, cls_dec;
    logic        illegal_q, illegal_d;
    logic [10:0] op11;

    assign op11 = opcode[OPW-1 -: 11];

    always_comb begin
        cls_dec = C_ILL;
        if (op11 == 11'b10001011000)      cls_dec = C_ADD;
        else if (op11 == 11'b11001011000) cls_dec = C_SUB;
        else if (op11 == 11'b10001010000) cls_dec = C_AND;
        else if (op11 == 11'b10101010000) cls_dec = C_ORR;
        else if (op11 == 11'b11111000010) cls_dec = C_LD;
        else if (op11 == 11'b11111000000) cls_dec = C_ST;
        else if (op11[10:3] == 8'b10110100) cls_dec = C_CBZ;
        else if (op11[10:5] == 6'b000101)   cls_dec = C_B;
    end

    // DECODE itself must act on the freshly decoded opcode; later states use the latched class
    assign cls_d     = (state_q == S_DECODE) ? cls_dec : cls_q;
    assign illegal_d = illegal_q | ((state_q == S_DECODE) && (cls_dec == C_ILL));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cls_q     <= C_ILL;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (run && mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (cls_dec)
                    C_B:     state_d = S_FETCH;
                    C_ILL:   state_d = S_HALT;
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (cls_q)
                    C_ADD, C_SUB, C_AND, C_ORR: state_d = S_WB;
                    C_LD, C_ST:                 state_d = S_MEM;
                    default:                    state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready) state_d = (cls_q == C_LD) ? S_WB : S_FETCH;
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Gating with reset keeps FETCH's input-dependent strobes low while reset is held
    always_comb begin
        inst_req = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        pc_src   = 2'b00;
        reg2Loc  = 1'b0;
        aluSrc   = 1'b0;
        aluOp    = ALU_AND;
        memRead  = 1'b0;
        memWrite = 1'b0;
        memToReg = 1'b0;
        regWrite = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    if (run) begin
                        inst_req = 1'b1;
                        if (mem_ready) begin
                            ir_write = 1'b1;
                            pc_write = 1'b1;
                        end
                    end
                end
                S_DECODE: begin
                    reg2Loc = (cls_dec == C_ST) || (cls_dec == C_CBZ);
                    if (cls_dec == C_B) begin
                        pc_write = 1'b1;
                        pc_src   = 2'b10;
                    end
                end
                S_EXEC: begin
                    case (cls_q)
                        C_ADD: aluOp = ALU_ADD;
                        C_SUB: aluOp = ALU_SUB;
                        C_AND: aluOp = ALU_AND;
                        C_ORR: aluOp = ALU_ORR;
                        C_LD: begin
                            aluSrc = 1'b1;
                            aluOp  = ALU_ADD;
                        end
                        C_ST: begin
                            aluSrc  = 1'b1;
                            aluOp   = ALU_ADD;
                            reg2Loc = 1'b1;
                        end
                        C_CBZ: begin
                            reg2Loc = 1'b1;
                            aluOp   = ALU_PASSB;
                            if (alu_zero) begin
                                pc_write = 1'b1;
                                pc_src   = 2'b01;
                            end
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    aluSrc = 1'b1;
                    aluOp  = ALU_ADD;
                    if (cls_q == C_LD) begin
                        memRead = 1'b1;
                    end else begin
                        memWrite = 1'b1;
                        reg2Loc  = 1'b1;
                    end
                end
                S_WB: begin
                    regWrite = 1'b1;
                    memToReg = (cls_q == C_LD);
                end
                default: ;
            endcase
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic [31:0] ret_cnt_q, ret_cnt_d;
    logic        busy, retire;

    assign busy   = !(((state_q == S_FETCH) && !run) || (state_q == S_HALT));
    assign retire = (state_q == S_WB)
                  || ((state_q == S_MEM) && (cls_q == C_ST) && mem_ready)
                  || ((state_q == S_EXEC) && (cls_q == C_CBZ))
                  || ((state_q == S_DECODE) && (cls_dec == C_B));

    assign cyc_cnt_d = busy   ? cyc_cnt_q + 32'd1 : cyc_cnt_q;
    assign ret_cnt_d = retire ? ret_cnt_q + 32'd1 : ret_cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cyc_cnt_q <= 32'd0;
            ret_cnt_q <= 32'd0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end

    assign cyc_cnt = cyc_cnt_q;
    assign ret_cnt = ret_cnt_q;
`endif

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Scoreboard bench for legv8_multicycle_ctrl: a per-cycle expected trace is built from the
// instruction-class rules, queued by the driver and compared by an independent monitor.
module tb_legv8_multicycle_ctrl;
    localparam int OPW  = 11;
    localparam int ALUW = 4;

    localparam logic [2:0] S_F = 3'b000, S_D = 3'b001, S_E = 3'b010,
                           S_M = 3'b011, S_W = 3'b100, S_H = 3'b111;
    localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_ORR = 3, K_LD = 4,
                   K_ST = 5, K_CBZ = 6, K_B = 7, K_ILL = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            run = 1'b0;
    logic            alu_zero = 1'b0;
    logic            mem_ready = 1'b0;
    logic [OPW-1:0]  opcode = '0;
    logic            inst_req, ir_write, pc_write, reg2Loc, aluSrc;
    logic            memRead, memWrite, memToReg, regWrite, illegal;
    logic [1:0]      pc_src;
    logic [ALUW-1:0] aluOp;
    logic [2:0]      state;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0]     cyc_cnt, ret_cnt;
`endif

    always #5 clock = ~clock;

    legv8_multicycle_ctrl #(.OPW(OPW), .ALUW(ALUW)) dut (
        .clock(clock), .reset(reset), .run(run), .opcode(opcode),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .inst_req(inst_req), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .reg2Loc(reg2Loc), .aluSrc(aluSrc), .aluOp(aluOp),
        .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
        .regWrite(regWrite), .state(state), .illegal(illegal)
`ifdef CTRL_PERF_CNT_EN
        , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
    );

    typedef struct packed {
        logic [2:0] st;
        logic       ireq, irw, pcw;
        logic [1:0] pcs;
        logic       r2l, asrc;
        logic [3:0] aop;
        logic       mr, mw, m2r, rw, ill;
    } out_t;

    typedef struct {
        logic        run, mrdy, az;
        logic [10:0] op;
        out_t        exp;
        int          id;
    } step_t;

    out_t  act;
    assign act = {state, inst_req, ir_write, pc_write, pc_src, reg2Loc, aluSrc,
                  aluOp, memRead, memWrite, memToReg, regWrite, illegal};

    step_t plan[$];
    step_t exp_q[$];
    step_t mon_s;
    int    mon_n;
    int    n_chk = 0;
    int    n_fail = 0;
    int    step_id = 0;

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, a, e);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [10:0] junk_op();
        return 11'($urandom);
    endfunction

    function automatic out_t o_st(input logic [2:0] st);
        out_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic int classify(input logic [10:0] op);
        logic [7:0] hi8;
        logic [5:0] hi6;
        hi8 = op[10:3];
        hi6 = op[10:5];
        if (op == 11'b10001011000) return K_ADD;
        if (op == 11'b11001011000) return K_SUB;
        if (op == 11'b10001010000) return K_AND;
        if (op == 11'b10101010000) return K_ORR;
        if (op == 11'b11111000010) return K_LD;
        if (op == 11'b11111000000) return K_ST;
        if (hi8 == 8'b10110100) return K_CBZ;
        if (hi6 == 6'b000101) return K_B;
        return K_ILL;
    endfunction

    function automatic logic [10:0] rand_legal_op();
        case ($urandom_range(0, 7))
            1: return 11'b11001011000;
            2: return 11'b10001010000;
            3: return 11'b10101010000;
            4: return 11'b11111000010;
            5: return 11'b11111000000;
            6: return {8'b10110100, 3'($urandom)};
            7: return {6'b000101, 5'($urandom)};
            default: return 11'b10001011000;
        endcase
    endfunction

    task automatic add(input logic r, input logic m, input logic z,
                       input logic [10:0] op, input out_t e);
        step_t s;
        s.run = r; s.mrdy = m; s.az = z; s.op = op; s.exp = e; s.id = step_id;
        step_id++;
        plan.push_back(s);
    endtask

    // One instruction: idle cycles, fetch waits, then the class-specific sequence
    task automatic gen_instr(input logic [10:0] op, input int idle, input int wf,
                             input int wm, input int azf);
        out_t e;
        int   c;
        logic z;
        c = classify(op);
        for (int i = 0; i < idle; i++) add(1'b0, rb(), rb(), junk_op(), o_st(S_F));
        for (int i = 0; i < wf; i++) begin
            e = o_st(S_F); e.ireq = 1'b1;
            add(1'b1, 1'b0, rb(), junk_op(), e);
        end
        e = o_st(S_F); e.ireq = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
        add(1'b1, 1'b1, rb(), junk_op(), e);
        e = o_st(S_D);
        e.r2l = (c == K_ST) || (c == K_CBZ);
        if (c == K_B) begin
            e.pcw = 1'b1; e.pcs = 2'b10;
        end
        add(rb(), rb(), rb(), op, e);
        if (c == K_B || c == K_ILL) return;
        z = (azf < 0) ? rb() : azf[0];
        e = o_st(S_E);
        case (c)
            K_ADD: e.aop = 4'b0010;
            K_SUB: e.aop = 4'b0110;
            K_AND: e.aop = 4'b0000;
            K_ORR: e.aop = 4'b0001;
            K_LD, K_ST: begin
                e.asrc = 1'b1; e.aop = 4'b0010; e.r2l = (c == K_ST);
            end
            default: begin
                e.r2l = 1'b1; e.aop = 4'b0111;
                e.pcw = z; e.pcs = z ? 2'b01 : 2'b00;
            end
        endcase
        add(rb(), rb(), z, junk_op(), e);
        if (c == K_CBZ) return;
        if (c == K_LD || c == K_ST) begin
            e = o_st(S_M); e.asrc = 1'b1; e.aop = 4'b0010;
            e.mr = (c == K_LD); e.mw = (c == K_ST); e.r2l = (c == K_ST);
            for (int i = 0; i < wm; i++) add(rb(), 1'b0, rb(), junk_op(), e);
            add(rb(), 1'b1, rb(), junk_op(), e);
            if (c == K_ST) return;
        end
        e = o_st(S_W); e.rw = 1'b1; e.m2r = (c == K_LD);
        add(rb(), rb(), rb(), junk_op(), e);
    endtask

    task automatic run_plan();
        step_t s;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            @(posedge clock);
            #1;
            run = s.run; mem_ready = s.mrdy; alu_zero = s.az; opcode = s.op;
            exp_q.push_back(s);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && exp_q.size() > 0) begin
            mon_s = exp_q.pop_front();
            check($sformatf("cycle%0d_outputs", mon_s.id), {13'd0, act}, {13'd0, mon_s.exp});
            mon_n = 32'(inst_req) + 32'(memRead) + 32'(memWrite);
            check($sformatf("cycle%0d_one_mem_req", mon_s.id), 32'(mon_n <= 1), 32'd1);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        run = 1'b1; mem_ready = 1'b1; opcode = 11'h7FF;
        #1 reset = 1'b1;
        #2 check("reset_outputs", {13'd0, act}, {13'd0, o_st(S_F)});
        @(negedge clock);
        run = 1'b0; mem_ready = 1'b0;
        reset = 1'b0;

        gen_instr(11'b10001011000, 0, 0, 0, -1); run_plan();   // ADD, zero wait
        gen_instr(11'b11111000010, 0, 0, 2, -1); run_plan();   // LDUR, 2 MEM waits
        gen_instr(11'b11111000000, 0, 0, 0, -1); run_plan();   // STUR
        gen_instr(11'b10110100101, 0, 0, 0, 1);  run_plan();   // CBZ taken
        gen_instr(11'b10110100010, 0, 0, 0, 0);  run_plan();   // CBZ not taken
        gen_instr(11'b00010110011, 0, 0, 0, -1); run_plan();   // B
        gen_instr(11'b11001011000, 2, 3, 0, -1); run_plan();   // SUB after idle and fetch waits

        for (int n = 0; n < 80; n++) begin
            gen_instr(rand_legal_op(), $urandom_range(0, 2), $urandom_range(0, 3),
                      $urandom_range(0, 3), -1);
            run_plan();
        end

        gen_instr(11'b11111111111, 1, 1, 0, -1);
        for (int i = 0; i < 20; i++) begin
            out_t e;
            e = o_st(S_H); e.ill = 1'b1;
            add(1'b1, rb(), rb(), junk_op(), e);
        end
        run_plan();

        @(negedge clock);
        #1 reset = 1'b1;
        #1 check("halt_reset_outputs", {13'd0, act}, {13'd0, o_st(S_F)});
        @(negedge clock);
        run = 1'b0; mem_ready = 1'b0;
        reset = 1'b0;

        // LDUR left waiting in MEM, then reset lands mid-cycle
        gen_instr(11'b11111000010, 0, 0, 6, -1);
        for (int i = 0; i < 6; i++) void'(plan.pop_back());
        run_plan();
        @(negedge clock);
        #1 reset = 1'b1;
        #1;
        check("reset_mem_memRead", 32'(memRead), 32'd0);
        check("reset_mem_state", 32'(state), 32'd0);
        check("reset_mem_outputs", {13'd0, act}, {13'd0, o_st(S_F)});
        @(negedge clock);
        run = 1'b0; mem_ready = 1'b0;
        reset = 1'b0;

        gen_instr(11'b10101010000, 0, 1, 0, -1); run_plan();   // ORR after recovery
        @(negedge clock);
        #1 check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
